// File: rtl/clint_ctrl.sv
// -----------------------------------------------------------------------------
// clint_ctrl -- core-local interrupt / trap sequencer
//
// Watches the ID-stage for ecall / ebreak / mret and, when CLINT_ASYNC_INT_EN
// is defined, the level machine-timer interrupt. On a trap it stalls the
// pipeline, writes mepc, mstatus and mcause over the CSR file's CLINT write
// port, and then redirects the PC to mtvec. On mret it rewrites mstatus and
// redirects the PC to mepc.
//
// Optional feature macro: CLINT_ASYNC_INT_EN
//   defined   : timer interrupt accepted when timer_irq_i && mstatus.MIE;
//               epc taken from the EX-stage jump target when a jump is in flight
//   undefined : only ecall / ebreak / mret; timer_irq_i, ex_jump_* unused
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   ecall_i/ebreak_i/mret_i  ID-stage instruction decode flags
//   inst_addr_i            PC of the ID-stage instruction
//   ex_jump_en_i/addr_i    EX-stage taken branch/jump and its target
//   timer_irq_i            level timer interrupt request
//   csr_mtvec_i/mepc_i/mstatus_i  live CSR values
//   clint_csr_wr_*_o       CSR write port (strobe, address, data)
//   hold_o                 whole-pipeline stall
//   int_jump_en_o/addr_o   PC redirect strobe and target
// -----------------------------------------------------------------------------
module clint_ctrl #(
  parameter int CPU_WIDTH      = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ecall_i,
  input  logic                      ebreak_i,
  input  logic                      mret_i,
  input  logic [CPU_WIDTH-1:0]      inst_addr_i,
  input  logic                      ex_jump_en_i,
  input  logic [CPU_WIDTH-1:0]      ex_jump_addr_i,
  input  logic                      timer_irq_i,
  input  logic [CPU_WIDTH-1:0]      csr_mtvec_i,
  input  logic [CPU_WIDTH-1:0]      csr_mepc_i,
  input  logic [CPU_WIDTH-1:0]      csr_mstatus_i,
  output logic                      clint_csr_wr_en_o,
  output logic [CSR_ADDR_WIDTH-1:0] clint_csr_wr_adder_o,
  output logic [CPU_WIDTH-1:0]      clint_csr_wr_data_o,
  output logic                      hold_o,
  output logic                      int_jump_en_o,
  output logic [CPU_WIDTH-1:0]      int_jump_addr_o
);

  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MSTATUS = CSR_ADDR_WIDTH'(12'h300);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MEPC    = CSR_ADDR_WIDTH'(12'h341);
  localparam logic [CSR_ADDR_WIDTH-1:0] ADDR_MCAUSE  = CSR_ADDR_WIDTH'(12'h342);

  localparam logic [CPU_WIDTH-1:0] CAUSE_ECALL  = CPU_WIDTH'(11);
  localparam logic [CPU_WIDTH-1:0] CAUSE_EBREAK = CPU_WIDTH'(3);
  localparam logic [CPU_WIDTH-1:0] CAUSE_TIMER  = {1'b1, {(CPU_WIDTH-4){1'b0}}, 3'd7};

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MSTATUS,
    S_W_MCAUSE,
    S_W_MRET,
    S_JUMP
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [CPU_WIDTH-1:0]   r_epc;
  logic [CPU_WIDTH-1:0]   r_cause;
  logic                   r_tgt_mepc;   // 1: return to mepc, 0: vector to mtvec

  logic                   w_irq;
  logic [CPU_WIDTH-1:0]   w_irq_epc;

  // Trap entry: save MIE into MPIE, then disable interrupts.
  function automatic logic [CPU_WIDTH-1:0] f_mstatus_trap(input logic [CPU_WIDTH-1:0] ms);
    logic [CPU_WIDTH-1:0] r;
    r    = ms;
    r[7] = ms[3];
    r[3] = 1'b0;
    return r;
  endfunction

  // Trap return: restore MIE from MPIE, then set MPIE.
  function automatic logic [CPU_WIDTH-1:0] f_mstatus_mret(input logic [CPU_WIDTH-1:0] ms);
    logic [CPU_WIDTH-1:0] r;
    r    = ms;
    r[3] = ms[7];
    r[7] = 1'b1;
    return r;
  endfunction

`ifdef CLINT_ASYNC_INT_EN
  assign w_irq     = timer_irq_i & csr_mstatus_i[3];
  // A taken EX-stage jump means the ID instruction is on the wrong path;
  // resume at the jump target instead.
  assign w_irq_epc = ex_jump_en_i ? ex_jump_addr_i : inst_addr_i;
`else
  logic w_unused;
  assign w_irq     = 1'b0;
  assign w_irq_epc = inst_addr_i;
  assign w_unused  = &{1'b0, timer_irq_i, ex_jump_en_i, ex_jump_addr_i};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_epc      <= '0;
      r_cause    <= '0;
      r_tgt_mepc <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE) begin
        if (ecall_i) begin
          r_epc      <= inst_addr_i;
          r_cause    <= CAUSE_ECALL;
          r_tgt_mepc <= 1'b0;
        end else if (ebreak_i) begin
          r_epc      <= inst_addr_i;
          r_cause    <= CAUSE_EBREAK;
          r_tgt_mepc <= 1'b0;
        end else if (mret_i) begin
          r_tgt_mepc <= 1'b1;
        end else if (w_irq) begin
          r_epc      <= w_irq_epc;
          r_cause    <= CAUSE_TIMER;
          r_tgt_mepc <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    w_next               = r_state;
    clint_csr_wr_en_o    = 1'b0;
    clint_csr_wr_adder_o = '0;
    clint_csr_wr_data_o  = '0;
    hold_o               = 1'b0;
    int_jump_en_o        = 1'b0;
    int_jump_addr_o      = '0;

    case (r_state)
      S_IDLE: begin
        if (ecall_i || ebreak_i) begin
          w_next = S_W_MEPC;
          hold_o = 1'b1;
        end else if (mret_i) begin
          w_next = S_W_MRET;
          hold_o = 1'b1;
        end else if (w_irq) begin
          w_next = S_W_MEPC;
          hold_o = 1'b1;
        end
      end
      S_W_MEPC: begin
        w_next               = S_W_MSTATUS;
        hold_o               = 1'b1;
        clint_csr_wr_en_o    = 1'b1;
        clint_csr_wr_adder_o = ADDR_MEPC;
        clint_csr_wr_data_o  = r_epc;
      end
      S_W_MSTATUS: begin
        w_next               = S_W_MCAUSE;
        hold_o               = 1'b1;
        clint_csr_wr_en_o    = 1'b1;
        clint_csr_wr_adder_o = ADDR_MSTATUS;
        clint_csr_wr_data_o  = f_mstatus_trap(csr_mstatus_i);
      end
      S_W_MCAUSE: begin
        w_next               = S_JUMP;
        hold_o               = 1'b1;
        clint_csr_wr_en_o    = 1'b1;
        clint_csr_wr_adder_o = ADDR_MCAUSE;
        clint_csr_wr_data_o  = r_cause;
      end
      S_W_MRET: begin
        w_next               = S_JUMP;
        hold_o               = 1'b1;
        clint_csr_wr_en_o    = 1'b1;
        clint_csr_wr_adder_o = ADDR_MSTATUS;
        clint_csr_wr_data_o  = f_mstatus_mret(csr_mstatus_i);
      end
      S_JUMP: begin
        w_next          = S_IDLE;
        hold_o          = 1'b1;
        int_jump_en_o   = 1'b1;
        // Live CSR value: mepc/mtvec already reflect any write just made.
        int_jump_addr_o = r_tgt_mepc ? csr_mepc_i : csr_mtvec_i;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase

    // Reset silences every output so no partial CSR write or redirect leaks out.
    if (rst) begin
      clint_csr_wr_en_o    = 1'b0;
      clint_csr_wr_adder_o = '0;
      clint_csr_wr_data_o  = '0;
      hold_o               = 1'b0;
      int_jump_en_o        = 1'b0;
      int_jump_addr_o      = '0;
    end
  end

endmodule
